// File: rtl/i2s_rx.sv
// I2S receiver: samples bck/lrck/din from an asynchronous bit clock in the clk domain and
// emits left/right sample pairs, flagging short and overlong slots.
module i2s_rx #(
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned I2S_DELAY   = 1,
  parameter int unsigned MAX_SLOT    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bck,
  input  logic                   lrck,
  input  logic                   din,
  output logic [SAMPLE_BITS-1:0] left,
  output logic [SAMPLE_BITS-1:0] right,
  output logic                   sample_valid,
  output logic                   frame_err
);

  localparam int unsigned CW        = $clog2(MAX_SLOT + 1);
  localparam logic [CW-1:0] LastBit = CW'(I2S_DELAY + SAMPLE_BITS - 1);
  localparam logic [CW-1:0] MaxCnt  = CW'(MAX_SLOT);
  localparam int FirstBitI          = int'(I2S_DELAY);
  localparam int LastBitI           = int'(I2S_DELAY + SAMPLE_BITS - 1);

  typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

  logic [1:0]             bck_sync, lrck_sync, din_sync;
  logic                   bck_prev;
  logic                   bck_rise;
  logic                   smp_valid, smp_lrck, smp_din;
  logic                   lrck_prev_q;
  logic [CW-1:0]          bit_cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, left_hold_q, word;
  logic                   left_ready_q;
  state_e                 state_q, state_d;
  logic                   change, in_frame, short_slot, long_slot, capture, word_done;
  int                     cnt_i;

  assign bck_rise = bck_sync[1] & ~bck_prev;

  always_comb begin
    change = smp_lrck != lrck_prev_q;
    if (change) begin
      cnt_d = '0;
    end else if (bit_cnt_q == MaxCnt) begin
      cnt_d = MaxCnt;
    end else begin
      cnt_d = bit_cnt_q + CW'(1);
    end
    in_frame   = state_q != StSync;
    // The old slot ended before its last data bit arrived.
    short_slot = in_frame && change && (bit_cnt_q < LastBit);
    long_slot  = in_frame && !change && (cnt_d == MaxCnt) && (bit_cnt_q != MaxCnt);
    state_d = state_q;
    if (long_slot) begin
      state_d = StSync;
    end else if (change) begin
      if (!smp_lrck) begin
        state_d = StLeft;
      end else if (in_frame) begin
        state_d = StRight;
      end
    end
    cnt_i     = int'(cnt_d);
    capture   = (state_d != StSync) && (cnt_i >= FirstBitI) && (cnt_i <= LastBitI);
    word      = {shift_q[SAMPLE_BITS-2:0], smp_din};
    word_done = capture && (cnt_d == LastBit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bck_sync     <= '0;
      lrck_sync    <= '0;
      din_sync     <= '0;
      bck_prev     <= 1'b0;
      smp_valid    <= 1'b0;
      smp_lrck     <= 1'b0;
      smp_din      <= 1'b0;
      lrck_prev_q  <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_ready_q <= 1'b0;
      state_q      <= StSync;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bck_sync     <= {bck_sync[0], bck};
      lrck_sync    <= {lrck_sync[0], lrck};
      din_sync     <= {din_sync[0], din};
      bck_prev     <= bck_sync[1];
      smp_valid    <= bck_rise;
      smp_lrck     <= lrck_sync[1];
      smp_din      <= din_sync[1];
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (smp_valid) begin
        lrck_prev_q <= smp_lrck;
        bit_cnt_q   <= cnt_d;
        state_q     <= state_d;
        frame_err   <= short_slot | long_slot;
        if (capture) begin
          shift_q <= word;
        end
        // A pair is only valid when the left word came from the slot just before.
        if (short_slot || long_slot || state_d == StSync || (change && state_d == StLeft)) begin
          left_ready_q <= 1'b0;
        end
        if (word_done && state_d == StLeft) begin
          left_hold_q  <= word;
          left_ready_q <= 1'b1;
        end
        if (word_done && state_d == StRight && left_ready_q) begin
          left         <= left_hold_q;
          right        <= word;
          sample_valid <= 1'b1;
          left_ready_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a Philips-mode instance driven by a frame table plus
// reset and left-justified latency sequences.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bck = 1'b0;
  logic        lrck = 1'b1;
  logic        din = 1'b0;
  logic [15:0] left_a, right_a, left_b, right_b;
  logic        sv_a, fe_a, sv_b, fe_b;

  int n_cmp = 0;
  int n_bad = 0;
  int nv_a = 0, ne_a = 0, nv_b = 0, ne_b = 0;
  logic [31:0] pairs[$];

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          llen;
    int          rlen;
    int          dv;
    int          de;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_BITS(16), .I2S_DELAY(1), .MAX_SLOT(32)) dut_a (
    .clk(clk), .rst(rst), .bck(bck), .lrck(lrck), .din(din),
    .left(left_a), .right(right_a), .sample_valid(sv_a), .frame_err(fe_a)
  );

  i2s_rx #(.SAMPLE_BITS(16), .I2S_DELAY(0), .MAX_SLOT(32)) dut_b (
    .clk(clk), .rst(rst), .bck(bck), .lrck(lrck), .din(din),
    .left(left_b), .right(right_b), .sample_valid(sv_b), .frame_err(fe_b)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (sv_a) begin
        nv_a++;
        pairs.push_back({left_a, right_a});
      end
      if (fe_a) ne_a++;
      if (sv_b) nv_b++;
      if (fe_b) ne_b++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One BCK period: drive on the falling half, 4 clk low then 4 clk high.
  task automatic send_bit(input logic lr, input logic d);
    bck  = 1'b0;
    lrck = lr;
    din  = d;
    repeat (4) @(negedge clk);
    bck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int delay, input int len);
    for (int i = 0; i < len; i++) begin
      int   j;
      logic b;
      j = i - delay;
      b = 1'b0;
      if (j >= 0 && j < 16) b = w[15-j];
      send_bit(lr, b);
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int v0, e0, vb0, eb0;
    tbl[0]  = '{16'hA5C3, 16'h0F0F, 32, 32, 1, 0, 16'hA5C3, 16'h0F0F};
    tbl[1]  = '{16'h1357, 16'h2468, 32, 32, 1, 0, 16'h1357, 16'h2468};
    tbl[2]  = '{16'hFFFF, 16'hAAAA, 10, 32, 0, 1, 16'h1357, 16'h2468};
    tbl[3]  = '{16'h1111, 16'h2222, 32, 32, 1, 0, 16'h1111, 16'h2222};
    tbl[4]  = '{16'h3333, 16'h4444, 32, 40, 1, 1, 16'h3333, 16'h4444};
    tbl[5]  = '{16'hCAFE, 16'hBEEF, 32, 32, 1, 0, 16'hCAFE, 16'hBEEF};
    tbl[6]  = '{16'h5555, 16'h6666, 40, 32, 0, 1, 16'hCAFE, 16'hBEEF};
    tbl[7]  = '{16'h9ABC, 16'hDEF0, 32, 32, 1, 0, 16'h9ABC, 16'hDEF0};
    tbl[8]  = '{16'h0001, 16'h8000, 24, 24, 1, 0, 16'h0001, 16'h8000};
    tbl[9]  = '{16'hFEDC, 16'hBA98, 17, 17, 1, 0, 16'hFEDC, 16'hBA98};
    tbl[10] = '{16'h7777, 16'h8888, 16, 32, 0, 1, 16'hFEDC, 16'hBA98};
    tbl[11] = '{16'h0F0F, 16'hF0F0, 32, 32, 1, 0, 16'h0F0F, 16'hF0F0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset left_a", 32'(left_a), 32'h0);
    check("reset right_a", 32'(right_a), 32'h0);
    check("reset valid_a", 32'(sv_a), 32'h0);
    check("reset err_a", 32'(fe_a), 32'h0);
    check("reset left_b", 32'(left_b), 32'h0);
    check("reset right_b", 32'(right_b), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Partial right slot seen while still in SYNC
    send_slot(1'b1, 16'h0, 1, 5);

    for (int k = 0; k < 12; k++) begin
      v0 = nv_a;
      e0 = ne_a;
      send_slot(1'b0, tbl[k].l, 1, tbl[k].llen);
      send_slot(1'b1, tbl[k].r, 1, tbl[k].rlen);
      settle();
      check($sformatf("vec%0d valid count", k), 32'(nv_a - v0), 32'(tbl[k].dv));
      check($sformatf("vec%0d err count", k), 32'(ne_a - e0), 32'(tbl[k].de));
      check($sformatf("vec%0d left", k), 32'(left_a), 32'(tbl[k].el));
      check($sformatf("vec%0d right", k), 32'(right_a), 32'(tbl[k].er));
    end

    // Reset in the middle of a right slot abandons the pending pair
    pairs.delete();
    v0 = nv_a;
    e0 = ne_a;
    send_slot(1'b0, 16'h5A5A, 1, 32);
    send_slot(1'b1, 16'h3C3C, 1, 10);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset left", 32'(left_a), 32'h0);
    check("midreset right", 32'(right_a), 32'h0);
    check("midreset valid", 32'(sv_a), 32'h0);
    rst = 1'b0;
    send_slot(1'b1, 16'h0, 1, 22);
    send_slot(1'b0, 16'h1234, 1, 32);
    send_slot(1'b1, 16'h5678, 1, 32);
    send_slot(1'b0, 16'h9ABC, 1, 32);
    send_slot(1'b1, 16'hDEF0, 1, 32);
    settle();
    check("midreset valid count", 32'(nv_a - v0), 32'd2);
    check("midreset err count", 32'(ne_a - e0), 32'd0);
    check("midreset pair count", 32'(pairs.size()), 32'd2);
    if (pairs.size() == 2) begin
      check("midreset pair0", pairs[0], 32'h1234_5678);
      check("midreset pair1", pairs[1], 32'h9ABC_DEF0);
    end

    // Left-justified, 16-bit slots, with exact latency on the last right bit
    vb0 = nv_b;
    eb0 = ne_b;
    send_slot(1'b0, 16'h8001, 0, 16);
    send_slot(1'b1, 16'h7FFE, 0, 16);
    send_slot(1'b0, 16'h8001, 0, 16);
    send_slot(1'b1, 16'h7FFE, 0, 15);
    bck  = 1'b0;
    lrck = 1'b1;
    din  = 1'b0;
    repeat (4) @(negedge clk);
    bck = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("latency cycle %0d", i), 32'(sv_b), (i == 4) ? 32'd1 : 32'd0);
    end
    settle();
    check("lj valid count", 32'(nv_b - vb0), 32'd2);
    check("lj err count", 32'(ne_b - eb0), 32'd0);
    check("lj left", 32'(left_b), 32'h8001);
    check("lj right", 32'(right_b), 32'h7FFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
